// File: rtl/mul_ctrl.sv
// Iterative radix-2 shift-add multiplier controller for the RV32M MUL/MULH/MULHSU/MULHU group.
// Stalls the pipeline for XLEN iterations, then pulses mul_done with the selected product word.
module mul_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            abort,
    output logic            mul_use,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] mcand_reg;
    logic [XLEN-1:0]   mplier_reg;
    logic              sign_reg;
    logic              hi_reg;
    logic [XLEN-1:0]   result_reg;

    logic              accept;
    logic              last_iter;
    logic              rs1_signed, rs2_signed;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [2*XLEN-1:0] partial, acc_sum, product;

    assign accept = (state_reg == S_IDLE) && mul_start && !funct3[2] && !abort;
    assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

    // MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
    assign rs1_signed = (funct3[1:0] != 2'b11);
    assign rs2_signed = !funct3[1];
    assign rs1_neg    = rs1_signed && rs1_val[XLEN-1];
    assign rs2_neg    = rs2_signed && rs2_val[XLEN-1];
    assign rs1_mag    = rs1_neg ? -rs1_val : rs1_val;
    assign rs2_mag    = rs2_neg ? -rs2_val : rs2_val;

    assign partial = mplier_reg[0] ? mcand_reg : '0;
    assign acc_sum = acc_reg + partial;
    assign product = sign_reg ? -acc_sum : acc_sum;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN: begin
                if (abort)          state_next = S_IDLE;
                else if (last_iter) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
            hi_reg     <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                mcand_reg  <= {{XLEN{1'b0}}, rs1_mag};
                mplier_reg <= rs2_mag;
                sign_reg   <= rs1_neg ^ rs2_neg;
                hi_reg     <= (funct3[1:0] != 2'b00);
                acc_reg    <= '0;
                cnt_reg    <= '0;
            end else if (state_reg == S_RUN && !abort) begin
                acc_reg    <= acc_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
                // Final iteration folds straight into the sign fix-up and word select.
                if (last_iter)
                    result_reg <= hi_reg ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
            end
        end
    end

    assign mul_result = result_reg;
    assign busy       = (state_reg != S_IDLE);
    assign mul_done   = (state_reg == S_DONE) && !abort;
    assign mul_use    = !rst && !abort && (accept || state_reg == S_RUN);

endmodule
